// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD RGB path: colour constants, rx state
// encoding, CRC-16-CCITT constants and coordinate helpers.
package lcd_pkg;

    localparam int COORD_W    = 12;
    localparam int H_DISP_DEF = 480;
    localparam int V_DISP_DEF = 272;

    typedef logic [COORD_W-1:0] coord_t;
    localparam coord_t COORD_MAX = '1;

    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] BLACK  = 24'h000000;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] CYAN   = 24'h00FFFF;
    localparam logic [23:0] ROYAL  = 24'h4169E1;

    typedef enum logic {
        SEARCH = 1'b0,
        ACTIVE = 1'b1
    } rx_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Increment that sticks at the top of the coordinate range.
    function automatic coord_t sat_inc(input coord_t v);
        return (v == COORD_MAX) ? v : v + coord_t'(1);
    endfunction

endpackage

// File: rtl/crc16_24b.sv
// One-step CRC-16-CCITT update over a 24-bit pixel, MSB first, no reflection.
module crc16_24b
    import lcd_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [23:0] data,
    output logic [15:0] crc_out
);

    // Unrolled bit-serial LFSR: 24 shifts, data bit 23 first.
    always_comb begin
        logic [15:0] c;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/lcd_rgb_rx.sv
// Parallel RGB video receiver: registers the DE/VS/pixel bus, recovers pixel
// coordinates, measures frame geometry and tracks format lock.
// Optional feature macro: FRAME_CRC_EN builds a per-frame CRC-16-CCITT over
// all valid pixels; without it frame_crc is tied to zero.
module lcd_rgb_rx
    import lcd_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEF,
    parameter int V_DISP = V_DISP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_vs,
    input  logic        vid_de,
    input  logic [23:0] vid_data,
    output logic        pix_valid,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [23:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic [11:0] meas_width,
    output logic [11:0] meas_height,
    output logic        fmt_err,
    output logic        locked,
    output logic [15:0] frame_crc
);

    localparam coord_t H_W    = coord_t'(H_DISP);
    localparam coord_t V_W    = coord_t'(V_DISP);
    localparam coord_t H_LAST = coord_t'(H_DISP - 1);

    logic        vs_r, de_r, vs_q, de_q;
    logic [23:0] data_r;

    rx_state_t   state, state_nxt;
    coord_t      x_cnt, y_cnt, last_w;
    logic        err_acc;
    logic [1:0]  good_cnt;

    logic        vs_rise, in_frame, close, line_end, pix_now, eol_next;
    coord_t      cur_x, cur_y, close_w, close_h;
    logic        close_err;

    // Input register stage plus one-cycle-delayed copies for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {vs_r, de_r, vs_q, de_q} <= '0;
            data_r                   <= '0;
        end else begin
            vs_r   <= vid_vs;
            de_r   <= vid_de;
            data_r <= vid_data;
            vs_q   <= vs_r;
            de_q   <= de_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_nxt;
    end

    // Next state and per-cycle event decode on the registered inputs.
    always_comb begin
        state_nxt = state;
        vs_rise   = vs_r & ~vs_q;
        in_frame  = (state == ACTIVE);
        unique case (state)
            SEARCH:  if (vs_rise) state_nxt = ACTIVE;
            ACTIVE:  state_nxt = ACTIVE;
            default: state_nxt = SEARCH;
        endcase
        // A line is terminated by DE falling or by VS rising over an open line.
        line_end = in_frame & de_q & (~de_r | vs_rise);
        close    = in_frame & vs_rise;
        // The pixel in the opening cycle already belongs to the new frame.
        pix_now  = de_r & (in_frame | vs_rise);
        cur_x    = vs_rise ? '0 : x_cnt;
        cur_y    = vs_rise ? '0 : y_cnt;
        close_h  = line_end ? sat_inc(y_cnt) : y_cnt;
        close_w  = line_end ? x_cnt : last_w;
        close_err = err_acc | (line_end & (x_cnt != H_W)) | (close_h != V_W);
        // pix_eol is registered alongside the pixel, so peek at the raw bus to
        // see whether this pixel really is the last one of its line.
        eol_next = pix_now & (cur_x == H_LAST) & (~vid_de | (vid_vs & ~vs_r));
    end

    // Coordinate counters, latched line width and frame error accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            last_w  <= '0;
            err_acc <= 1'b0;
        end else if (vs_rise) begin
            x_cnt   <= de_r ? coord_t'(1) : '0;
            y_cnt   <= '0;
            last_w  <= '0;
            err_acc <= 1'b0;
        end else if (in_frame) begin
            if (line_end) begin
                last_w  <= x_cnt;
                y_cnt   <= sat_inc(y_cnt);
                err_acc <= err_acc | (x_cnt != H_W);
                x_cnt   <= '0;
            end else if (de_r) begin
                x_cnt   <= sat_inc(x_cnt);
            end
        end
    end

    // Pixel output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
        end else begin
            pix_valid <= pix_now;
            pix_x     <= cur_x;
            pix_y     <= cur_y;
            pix_data  <= data_r;
            pix_sof   <= pix_now & (cur_x == '0) & (cur_y == '0);
            pix_eol   <= eol_next;
        end
    end

    // Frame close: publish measurements, pulse frame_done, update lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done  <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            fmt_err     <= 1'b0;
            locked      <= 1'b0;
            good_cnt    <= '0;
        end else begin
            frame_done <= close;
            if (close) begin
                meas_width  <= close_w;
                meas_height <= close_h;
                fmt_err     <= close_err;
                if (close_err) begin
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end else begin
                    good_cnt <= (good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1;
                    locked   <= locked | (good_cnt != 2'd0);
                end
            end
        end
    end

`ifdef FRAME_CRC_EN
    logic [15:0] crc_acc, crc_base, crc_step, crc_q;

    // A new frame restarts from CRC_INIT, including a pixel in the opening cycle.
    assign crc_base = vs_rise ? CRC_INIT : crc_acc;

    crc16_24b u_crc (
        .crc_in  (crc_base),
        .data    (data_r),
        .crc_out (crc_step)
    );

    // Running CRC over valid pixels; snapshot it when the frame closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_acc <= CRC_INIT;
            crc_q   <= '0;
        end else begin
            if (pix_now)      crc_acc <= crc_step;
            else if (vs_rise) crc_acc <= CRC_INIT;
            if (close)        crc_q   <= crc_acc;
        end
    end

    assign frame_crc = crc_q;
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed bench for lcd_rgb_rx on a reduced 16x8 geometry.
module tb_lcd_rgb_rx;

    localparam int H = 16;
    localparam int V = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_vs = 1'b0, vid_de = 1'b0;
    logic [23:0] vid_data = '0;
    logic        pix_valid, pix_sof, pix_eol, frame_done, fmt_err, locked;
    logic [11:0] pix_x, pix_y, meas_width, meas_height;
    logic [23:0] pix_data;
    logic [15:0] frame_crc;

    int checks = 0;
    int errors = 0;

    // Observation counters filled by the sampler.
    int n_valid, n_eol, n_sof, n_done, seq_bad, eol_bad, sof_bad, data_bad, ymax;
    int d_w, d_h, d_err, d_lock, d_pv, d_px, d_py, d_sof, lock1;
    logic [15:0] d_crc;
    logic        prev_v;
    logic [11:0] prev_x;
    logic        chk_data = 1'b0;
    logic [23:0] solid = 24'hFF0000;
    int          mode = 0;

    lcd_rgb_rx #(.H_DISP(H), .V_DISP(V)) dut (
        .clk(clk), .rst_n(rst_n), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
        .meas_width(meas_width), .meas_height(meas_height), .fmt_err(fmt_err),
        .locked(locked), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Sample outputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pix_valid) begin
            n_valid++;
            if (prev_v ? (pix_x != 12'd0 && pix_x != prev_x + 12'd1) : (pix_x != 12'd0)) seq_bad++;
            if (chk_data && pix_data !== solid) data_bad++;
            if (int'(pix_y) > ymax) ymax = int'(pix_y);
        end
        if (pix_eol) begin
            n_eol++;
            if (!pix_valid || pix_x != 12'(H - 1)) eol_bad++;
        end
        if (pix_sof) begin
            n_sof++;
            if (!pix_valid || pix_x != 12'd0 || pix_y != 12'd0) sof_bad++;
        end
        if (frame_done) begin
            n_done++;
            d_w = int'(meas_width); d_h = int'(meas_height); d_err = int'(fmt_err);
            d_lock = int'(locked); d_crc = frame_crc;
            d_pv = int'(pix_valid); d_px = int'(pix_x); d_py = int'(pix_y); d_sof = int'(pix_sof);
            if (n_done == 1) lock1 = int'(locked);
        end
        prev_v = pix_valid;
        prev_x = pix_x;
    end

    task automatic clr_stats();
        n_valid = 0; n_eol = 0; n_sof = 0; n_done = 0; seq_bad = 0; eol_bad = 0;
        sof_bad = 0; data_bad = 0; ymax = 0; lock1 = -1; d_w = -1; d_h = -1; d_err = -1;
        d_lock = -1; d_pv = -1; d_px = -1; d_py = -1; d_sof = -1; d_crc = 16'hxxxx;
    endtask

    task automatic cyc(input logic v, input logic d, input logic [23:0] px);
        @(negedge clk);
        vid_vs = v; vid_de = d; vid_data = px;
    endtask

    function automatic logic [23:0] pixval(input int x, input int y);
        return (mode == 0) ? solid : 24'(x * y);
    endfunction

    task automatic drive_line(input int w, input int y);
        for (int x = 0; x < w; x++) cyc(1'b0, 1'b1, pixval(x, y));
        repeat (4) cyc(1'b0, 1'b0, 24'h0);
    endtask

    task automatic drive_frame(input int bad_line, input int bad_w);
        for (int y = 0; y < V; y++) drive_line((y == bad_line) ? bad_w : H, y);
    endtask

    task automatic vs_pulse();
        cyc(1'b1, 1'b0, 24'h0);
        repeat (4) cyc(1'b0, 1'b0, 24'h0);
    endtask

    // Byte-at-a-time CRC-16-CCITT reference.
    function automatic logic [15:0] crc_px(input logic [15:0] c_in, input logic [23:0] d);
        logic [15:0] c;
        logic [7:0]  b;
        c = c_in;
        for (int k = 2; k >= 0; k--) begin
            b = d[k*8 +: 8];
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc_frame();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) c = crc_px(c, pixval(x, y));
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_data, pix_sof, pix_eol, frame_done, meas_width,
             meas_height, fmt_err, locked, frame_crc} !== '0) begin
            errors++; $display("FAIL reset_outputs got nonzero (x=%h y=%h data=%h) want 0", pix_x, pix_y, pix_data);
        end
        cyc(1'b0, 1'b0, 24'h0);
        rst_n = 1'b1;
        clr_stats();
        solid = 24'hFF0000;
        drive_line(H, 0);
        repeat (3) cyc(1'b0, 1'b0, 24'h0);
        checks++;
        if (n_valid !== 0) begin errors++; $display("FAIL search_de got %0d valid want 0", n_valid); end
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL search_done got %0d want 0", n_done); end
    endtask

    task automatic test_clean_frames();
        clr_stats();
        chk_data = 1'b1; mode = 0; solid = 24'hFF0000;
        vs_pulse();
        // first pixel latency: two edges after the input cycle
        cyc(1'b0, 1'b1, solid);
        cyc(1'b0, 1'b1, solid);
        checks++;
        if (pix_valid !== 1'b0) begin errors++; $display("FAIL pix_latency1 got %b want 0", pix_valid); end
        cyc(1'b0, 1'b1, solid);
        checks++;
        if ({pix_valid, pix_sof, pix_x, pix_y} !== {1'b1, 1'b1, 24'h0}) begin
            errors++; $display("FAIL pix_latency2 got v=%b sof=%b x=%0d y=%0d want 1 1 0 0", pix_valid, pix_sof, pix_x, pix_y);
        end
        for (int x = 3; x < H; x++) cyc(1'b0, 1'b1, solid);
        repeat (4) cyc(1'b0, 1'b0, 24'h0);
        for (int y = 1; y < V; y++) drive_line(H, y);
        vs_pulse();
        drive_frame(-1, 0);
        cyc(1'b1, 1'b0, 24'h0);
        cyc(1'b0, 1'b0, 24'h0);
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL done_latency1 got %b want 0", frame_done); end
        cyc(1'b0, 1'b0, 24'h0);
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL done_latency2 got %b want 1", frame_done); end
        repeat (3) cyc(1'b0, 1'b0, 24'h0);
        checks++; if (n_done !== 2) begin errors++; $display("FAIL clean_ndone got %0d want 2", n_done); end
        checks++; if (d_w !== H) begin errors++; $display("FAIL clean_width got %0d want %0d", d_w, H); end
        checks++; if (d_h !== V) begin errors++; $display("FAIL clean_height got %0d want %0d", d_h, V); end
        checks++; if (d_err !== 0) begin errors++; $display("FAIL clean_err got %0d want 0", d_err); end
        checks++; if (lock1 !== 0) begin errors++; $display("FAIL lock_first got %0d want 0", lock1); end
        checks++; if (d_lock !== 1) begin errors++; $display("FAIL lock_second got %0d want 1", d_lock); end
        checks++; if (n_valid !== 2 * H * V) begin errors++; $display("FAIL clean_pixels got %0d want %0d", n_valid, 2 * H * V); end
        checks++; if (n_eol !== 2 * V) begin errors++; $display("FAIL clean_eol got %0d want %0d", n_eol, 2 * V); end
        checks++; if (n_sof !== 2) begin errors++; $display("FAIL clean_sof got %0d want 2", n_sof); end
        checks++;
        if (seq_bad + eol_bad + sof_bad + data_bad !== 0) begin
            errors++; $display("FAIL clean_stream got seq=%0d eol=%0d sof=%0d data=%0d want 0", seq_bad, eol_bad, sof_bad, data_bad);
        end
        checks++; if (ymax !== V - 1) begin errors++; $display("FAIL clean_ymax got %0d want %0d", ymax, V - 1); end
        chk_data = 1'b0;
    endtask

    task automatic test_bad_line();
        clr_stats();
        drive_frame(5, H - 1);
        vs_pulse();
        checks++; if (d_err !== 1) begin errors++; $display("FAIL bad_err got %0d want 1", d_err); end
        checks++; if (d_w !== H) begin errors++; $display("FAIL bad_width got %0d want %0d", d_w, H); end
        checks++; if (d_h !== V) begin errors++; $display("FAIL bad_height got %0d want %0d", d_h, V); end
        checks++; if (d_lock !== 0) begin errors++; $display("FAIL bad_lock got %0d want 0", d_lock); end
        checks++; if (n_eol !== V - 1) begin errors++; $display("FAIL bad_eol got %0d want %0d", n_eol, V - 1); end
        drive_frame(-1, 0);
        vs_pulse();
        checks++;
        if (d_err !== 0 || d_lock !== 0) begin errors++; $display("FAIL relock1 got err=%0d lock=%0d want 0 0", d_err, d_lock); end
        drive_frame(-1, 0);
        vs_pulse();
        checks++;
        if (d_err !== 0 || d_lock !== 1) begin errors++; $display("FAIL relock2 got err=%0d lock=%0d want 0 1", d_err, d_lock); end
    endtask

    task automatic test_vs_mid_line();
        clr_stats();
        for (int y = 0; y < V - 1; y++) drive_line(H, y);
        repeat (10) cyc(1'b0, 1'b1, solid);
        cyc(1'b1, 1'b1, solid);
        for (int x = 1; x < H; x++) cyc(1'b0, 1'b1, solid);
        repeat (4) cyc(1'b0, 1'b0, 24'h0);
        checks++; if (n_done !== 1) begin errors++; $display("FAIL mid_ndone got %0d want 1", n_done); end
        checks++; if (d_w !== 10) begin errors++; $display("FAIL mid_width got %0d want 10", d_w); end
        checks++; if (d_h !== V) begin errors++; $display("FAIL mid_height got %0d want %0d", d_h, V); end
        checks++; if (d_err !== 1) begin errors++; $display("FAIL mid_err got %0d want 1", d_err); end
        checks++;
        if (d_pv !== 1 || d_px !== 0 || d_py !== 0 || d_sof !== 1) begin
            errors++; $display("FAIL mid_newpix got v=%0d x=%0d y=%0d sof=%0d want 1 0 0 1", d_pv, d_px, d_py, d_sof);
        end
        checks++; if (n_eol !== V) begin errors++; $display("FAIL mid_eol got %0d want %0d", n_eol, V); end
        checks++; if (seq_bad !== 0) begin errors++; $display("FAIL mid_seq got %0d want 0", seq_bad); end
    endtask

    task automatic test_reset_mid();
        for (int y = 1; y < 4; y++) drive_line(H, y);
        repeat (5) cyc(1'b0, 1'b1, solid);
        cyc(1'b0, 1'b1, solid);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pix_valid, pix_x, pix_y, meas_width, meas_height, fmt_err} !== '0) begin
            errors++; $display("FAIL rst_mid_clear got v=%b x=%0d y=%0d w=%0d h=%0d err=%b want 0",
                               pix_valid, pix_x, pix_y, meas_width, meas_height, fmt_err);
        end
        repeat (3) cyc(1'b0, 1'b0, 24'h0);
        rst_n = 1'b1;
        clr_stats();
        vs_pulse();
        drive_frame(-1, 0);
        checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_first_vs got %0d done want 0", n_done); end
        checks++; if (n_valid !== H * V) begin errors++; $display("FAIL rst_pixels got %0d want %0d", n_valid, H * V); end
        vs_pulse();
        checks++;
        if (n_done !== 1 || d_w !== H || d_h !== V || d_err !== 0) begin
            errors++; $display("FAIL rst_second_vs got n=%0d w=%0d h=%0d err=%0d want 1 %0d %0d 0", n_done, d_w, d_h, d_err, H, V);
        end
    endtask

    task automatic test_crc();
        logic [15:0] exp0, exp1;
        clr_stats();
        mode = 0; solid = 24'h000000;
        drive_frame(-1, 0);
        vs_pulse();
`ifdef FRAME_CRC_EN
        exp0 = crc_frame();
`else
        exp0 = 16'h0000;
`endif
        checks++; if (d_crc !== exp0) begin errors++; $display("FAIL crc_black got %h want %h", d_crc, exp0); end
        mode = 1;
        drive_frame(-1, 0);
        vs_pulse();
`ifdef FRAME_CRC_EN
        exp1 = crc_frame();
`else
        exp1 = 16'h0000;
`endif
        checks++; if (d_crc !== exp1) begin errors++; $display("FAIL crc_xy got %h want %h", d_crc, exp1); end
        checks++; if (n_done !== 2) begin errors++; $display("FAIL crc_ndone got %0d want 2", n_done); end
    endtask

    initial begin
        clr_stats();
        prev_v = 1'b0;
        prev_x = '0;
        test_reset();
        test_clean_frames();
        test_bad_line();
        test_vs_mid_line();
        test_reset_mid();
        test_crc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
